lfsr_prng: RTL
==============

// Module: lfsr_prng
// PURPOSE
//   Parametrised Fibonacci LFSR pseudo-random generator; next generation of the 8-bit lfsr.
//   Adds: generic width/taps, STEPS shifts per clock, explicit load/hold, reset seed,
//   optional period measurement. Feeds pattern sources and random stimulus in the lab designs.
// PARAMETERS
//   WIDTH      8      state/dout width, 3..32
//   TAPS       8'h1D  feedback mask; bit i set => s[i] XORed into feedback (default = bits 4,3,2,0)
//   STEPS      1      LFSR shifts per enabled clock, 1..WIDTH
//   RESET_SEED 8'h01  state after rst (any value incl. 0 legal)
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous reset, active-high
//   load     in   1      load din into state and seed register
//   en       in   1      advance STEPS shifts this cycle
//   din      in   WIDTH  seed value
//   dout     out  WIDTH  current state (registered)
//   valid    out  1      1 once a load has completed since rst
//   wrap     out  1      1-cycle pulse: state returned to seed      (LFSR_PERIOD_EN only)
//   period   out  WIDTH+1 last measured period, in shifts           (LFSR_PERIOD_EN only)
// BEHAVIOUR
//   - Single shift: fb = ^(s & TAPS) ^ (s == 0); s_next = {fb, s[WIDTH-1:1]}.
//     All-zero term guarantees escape from 0: 0 -> {1'b1, {WIDTH-1{1'b0}}}.
//   - Priority per clock: rst > load > en > hold. en ignored when load=1.
//   - rst: dout=RESET_SEED, seed=RESET_SEED, valid=0, wrap=0, period=0, step count=0.
//   - load: dout=din, seed=din, valid=1, step count=0, wrap=0; period unchanged. Visible next cycle.
//   - en (load=0): dout <= STEPS chained single shifts of dout; latency 1 clock.
//   - en=0, load=0: all state held; wrap=0.
//   - valid only reports seed origin; shifting with valid=0 is allowed (from RESET_SEED).
//   - rst asserted mid-run aborts immediately; no partial STEPS chain retained.
//   - Period logic (macro on):
//     * cnt (WIDTH+1 bits) counts shifts since last load/wrap.
//     * Each substep k (1..STEPS) of an enabled clock compares result to seed; first hit k:
//       period <= cnt + k, wrap=1 next cycle, cnt <= STEPS - k.
//     * No hit: cnt <= cnt + STEPS, saturating at all-ones; a saturated cnt never reports wrap.
//     * load in same cycle as a would-be hit: load wins, no wrap.
// CONFIGURATION
//   LFSR_PERIOD_EN defined: cnt, seed compare, wrap, period as above.
//   Not defined: no counter or comparators built; wrap=0, period=0 constantly;
//   seed register omitted; dout/valid identical to the macro-on build.
// TESTING
//   1 rst; load din=8'h01; en x2 (STEPS=1) -> dout 8'h01, 8'h80, 8'h40.
//   2 load din=8'h00; en x1 -> dout 8'h80 (all-zero escape).
//   3 STEPS=4, load 8'h01; en x1 -> dout equals 4 chained shifts of STEPS=1 model.
//   4 Macro on, load 8'h01, en held -> wrap pulses at reference-model period;
//     period equals it; second wrap same distance later.
//   5 load and en together; then en=0 for 3 cycles -> dout=din, then held, wrap=0.
//   6 rst mid-run -> next cycle dout=RESET_SEED, valid=0, period=0, wrap=0.

Source files
------------

// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci LFSR with STEPS shifts per enabled clock, load/hold and reset seed.
// Define LFSR_PERIOD_EN to build the seed-return detector (wrap pulse and period measurement).
module lfsr_prng #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'h1D,
  parameter int unsigned      STEPS      = 1,
  parameter logic [WIDTH-1:0] RESET_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             wrap,
  output logic [WIDTH:0]   period
);

  // The all-zero term forces a 1 into the top bit so the zero state is never a trap.
  function automatic logic [WIDTH-1:0] lfsr_shift(input logic [WIDTH-1:0] s);
    logic fb;
    fb = (^(s & TAPS)) ^ (s == '0);
    return {fb, s[WIDTH-1:1]};
  endfunction

  logic [WIDTH-1:0] state_q, state_d;
  logic             valid_q;

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   period_q, period_d;
  logic             wrap_q;
  logic             hit;
  logic [WIDTH:0]   hit_k;
  logic             wrap_hit;
  logic [WIDTH+1:0] cnt_sum;

  // Chain the substeps and remember the first one that lands back on the seed.
  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    hit_k   = '0;
    for (int unsigned k = 1; k <= STEPS; k++) begin
      state_d = lfsr_shift(state_d);
      if (!hit && (state_d == seed_q)) begin
        hit   = 1'b1;
        hit_k = (WIDTH+1)'(k);
      end
    end
  end

  // A saturated count means the true period is unknown, so it never reports a wrap.
  always_comb begin
    cnt_sum  = {1'b0, cnt_q} + (WIDTH+2)'(STEPS);
    wrap_hit = hit && (cnt_q != '1);
    period_d = period_q;
    if (wrap_hit) begin
      period_d = cnt_q + hit_k;
      cnt_d    = (WIDTH+1)'(STEPS) - hit_k;
    end else if (cnt_sum[WIDTH+1]) begin
      cnt_d = '1;
    end else begin
      cnt_d = cnt_sum[WIDTH:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RESET_SEED;
      valid_q  <= 1'b0;
      seed_q   <= RESET_SEED;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
    end else if (load) begin
      state_q <= din;
      valid_q <= 1'b1;
      seed_q  <= din;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else if (en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_hit;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign wrap   = wrap_q;
  assign period = period_q;
`else
  always_comb begin
    state_d = state_q;
    for (int unsigned k = 0; k < STEPS; k++) begin
      state_d = lfsr_shift(state_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_SEED;
      valid_q <= 1'b0;
    end else if (load) begin
      state_q <= din;
      valid_q <= 1'b1;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  assign wrap   = 1'b0;
  assign period = '0;
`endif

  assign dout  = state_q;
  assign valid = valid_q;

endmodule
